// File: rtl/sdram_port_arbiter_if.sv
// SDRAM controller port shared by the download writer and the cassette reader.
// master = arbiter side, slave = SDRAM controller side.
`timescale 1ns/1ps
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Sequenced arbiter for the 8-bit SDRAM port: buffered download writes with
// priority, cassette reads with anti-starvation, and an acknowledge timeout.
`timescale 1ns/1ps
module sdram_port_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 8,
    parameter int WR_BURST_MAX = 4,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                wr_stb,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_busy,
    input  logic                rd_stb,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    sdram_port_arbiter_if.master mem,
    input  logic                clr_flags,
    output logic                wr_ovf,
    output logic                rd_drop,
    output logic                ack_err
);
    localparam int RUN_W = $clog2(WR_BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t            state_q, state_d;
    logic              wr_full_q, wr_full_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [RUN_W-1:0]  wr_run_q, wr_run_d;
    logic [3:0]        tcnt_q, tcnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ovf_q, wr_ovf_d;
    logic              rd_drop_q, rd_drop_d;
    logic              ack_err_q, ack_err_d;

    logic busy, done, tout, leave, wr_rel, grant_wr, grant_rd;
    logic ovf_set, drop_set;

    always_comb begin
        state_d    = state_q;
        wr_full_d  = wr_full_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;
        wr_run_d   = wr_run_q;
        tcnt_d     = tcnt_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_set    = 1'b0;
        drop_set   = 1'b0;

        busy     = (state_q != IDLE);
        done     = busy && mem.mem_ack;
        tout     = busy && !mem.mem_ack
                   && (tcnt_q == 4'(ACK_TIMEOUT - 1));
        leave    = done || tout;
        wr_rel   = (state_q == WR) && leave;
        grant_wr = (state_q == IDLE) && wr_full_q
                   && (!rd_pend_q || wr_run_q < RUN_W'(WR_BURST_MAX));
        grant_rd = (state_q == IDLE) && !grant_wr && rd_pend_q;

        if (grant_wr) begin
            state_d    = WR;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = wr_addr_q;
            mem_din_d  = wr_data_q;
            tcnt_d     = '0;
        end else if (grant_rd) begin
            state_d    = RD;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = rd_addr_q;
            tcnt_d     = '0;
        end else if (leave) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            if (state_q == RD) begin
                rd_valid_d = 1'b1;
                rd_data_d  = done ? mem.mem_dout : '1;
            end
        end else if (busy) begin
            tcnt_d = tcnt_q + 4'd1;
        end

        // A strobe on the release edge refills the freed entry
        if (wr_rel) wr_full_d = 1'b0;
        if (wr_stb) begin
            if (!wr_full_q || wr_rel) begin
                wr_full_d = 1'b1;
                wr_addr_d = wr_addr;
                wr_data_d = wr_data;
            end else begin
                ovf_set = 1'b1;
            end
        end

        if (grant_rd) rd_pend_d = 1'b0;
        if (rd_stb) begin
            if (state_q == RD) begin
                drop_set = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
                rd_addr_d = rd_addr;
            end
        end

        if (grant_rd)
            wr_run_d = '0;
        else if (grant_wr && rd_pend_q)
            wr_run_d = wr_run_q + 1'b1;
        else if (!rd_pend_q)
            wr_run_d = '0;

        wr_ovf_d  = ovf_set  || (wr_ovf_q  && !clr_flags);
        rd_drop_d = drop_set || (rd_drop_q && !clr_flags);
        ack_err_d = tout     || (ack_err_q && !clr_flags);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_full_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            wr_run_q   <= '0;
            tcnt_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ovf_q   <= 1'b0;
            rd_drop_q  <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_full_q  <= wr_full_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            wr_run_q   <= wr_run_d;
            tcnt_q     <= tcnt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ovf_q   <= wr_ovf_d;
            rd_drop_q  <= rd_drop_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign wr_busy      = wr_full_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_din  = mem_din_q;
    assign wr_ovf       = wr_ovf_q;
    assign rd_drop      = rd_drop_q;
    assign ack_err      = ack_err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: SDRAM responder with a transaction-level
// grant/read-result scoreboard plus directed literal checks.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    localparam int AW = 25;
    localparam int DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_stb = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_busy;
    logic          rd_stb = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          clr_flags = 1'b0;
    logic          wr_ovf, rd_drop, ack_err;

    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    sdram_port_arbiter dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_busy   (wr_busy),
        .rd_stb    (rd_stb),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .mem       (mem),
        .clr_flags (clr_flags),
        .wr_ovf    (wr_ovf),
        .rd_drop   (rd_drop),
        .ack_err   (ack_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } req_t;

    req_t          exp_q[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] mem_img [int];
    int            ack_dly = 3;
    int            n_grant = 0;
    int            n_rdv   = 0;
    int            n_chk   = 0;
    int            n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Memory contents seen by reads: acked writes, else an address pattern
    function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
        if (mem_img.exists(int'(a))) return mem_img[int'(a)];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic req_t mk(input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
        req_t r;
        r.we = we; r.addr = a; r.din = d;
        return r;
    endfunction

    // Responder and grant scoreboard; ack_dly==0 means never acknowledge
    initial begin : responder
        req_t g, e;
        bit   seen;
        seen = 1'b0;
        mem.mem_ack  = 1'b0;
        mem.mem_dout = 8'hEE;
        forever begin
            @(negedge clk_sys);
            if (mem.mem_req && !seen) begin
                seen = 1'b1;
                n_grant++;
                g = mk(mem.mem_we, mem.mem_addr, mem.mem_din);
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL grant_unexpected: got we=%0d addr=%h, required none",
                             g.we, g.addr);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_we", 32'(g.we), 32'(e.we));
                    check("grant_addr", 32'(g.addr), 32'(e.addr));
                    if (e.we) check("grant_din", 32'(g.din), 32'(e.din));
                end
                if (ack_dly > 0) begin
                    for (int i = 1; i < ack_dly; i++) begin
                        @(negedge clk_sys);
                        check("req_hold", 32'(mem.mem_req), 32'd1);
                        check("addr_hold", 32'(mem.mem_addr), 32'(g.addr));
                    end
                    mem.mem_ack  = 1'b1;
                    mem.mem_dout = g.we ? 8'hEE : img(g.addr);
                    if (g.we) mem_img[int'(g.addr)] = g.din;
                    @(negedge clk_sys);
                    mem.mem_ack  = 1'b0;
                    mem.mem_dout = 8'hEE;
                    check("req_drop_after_ack", 32'(mem.mem_req), 32'd0);
                    seen = 1'b0;
                end
            end else if (!mem.mem_req) begin
                seen = 1'b0;
            end
        end
    end

    initial begin : rd_compare
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (rd_valid) begin
                n_rdv++;
                check("rd_valid_pulse", 32'(prev_v), 32'd0);
                if (exp_rd.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rd_unexpected: got %h, required no pulse", rd_data);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
                end
            end
            prev_v = rd_valid;
        end
    end

    task automatic wr_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_stb = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk_sys);
        wr_stb = 1'b0;
    endtask

    task automatic rd_strobe(input logic [AW-1:0] a);
        rd_stb = 1'b1; rd_addr = a;
        @(negedge clk_sys);
        rd_stb = 1'b0;
    endtask

    task automatic clr();
        clr_flags = 1'b1;
        @(negedge clk_sys);
        clr_flags = 1'b0;
    endtask

    task automatic wait_grant(input string nm);
        logic last;
        bit   hit;
        last = mem.mem_req;
        hit  = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk_sys);
            if (mem.mem_req && !last) hit = 1'b1;
            last = mem.mem_req;
        end
        check({nm, "_grant_seen"}, 32'(hit), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (k < 300 && (exp_q.size() != 0 || exp_rd.size() != 0
                           || mem.mem_req || wr_busy)) begin
            @(negedge clk_sys);
            k++;
        end
        check({nm, "_idle_reached"}, 32'(k < 300), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g0, n;
        repeat (3) @(negedge clk_sys);
        check("rst_mem_req", 32'(mem.mem_req), 32'd0);
        check("rst_wr_busy", 32'(wr_busy), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_ovf", 32'(wr_ovf), 32'd0);
        check("rst_rd_drop", 32'(rd_drop), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Single write, ack 3 cycles after mem_req
        ack_dly = 3;
        exp_q.push_back(mk(1'b1, 25'h000123, 8'hA5));
        wr_strobe(25'h000123, 8'hA5);
        check("t1_busy_set", 32'(wr_busy), 32'd1);
        check("t1_req_lat1", 32'(mem.mem_req), 32'd0);
        @(negedge clk_sys);
        check("t1_req_lat2", 32'(mem.mem_req), 32'd1);
        check("t1_we", 32'(mem.mem_we), 32'd1);
        check("t1_addr", 32'(mem.mem_addr), 32'h123);
        check("t1_din", 32'(mem.mem_din), 32'hA5);
        repeat (3) @(negedge clk_sys);
        check("t1_req_low", 32'(mem.mem_req), 32'd0);
        check("t1_busy_clr", 32'(wr_busy), 32'd0);
        wait_idle("t1");

        // Single read with a dropped strobe during service
        mem_img[32'h10] = 8'h3C;
        exp_q.push_back(mk(1'b0, 25'h10, 8'h00));
        exp_rd.push_back(img(25'h10));
        rd_strobe(25'h10);
        wait_grant("t2");
        rd_strobe(25'h44);
        check("t2_rd_drop", 32'(rd_drop), 32'd1);
        wait_idle("t2");
        check("t2_rd_data", 32'(rd_data), 32'h3C);
        check("t2_rdv_count", 32'(n_rdv), 32'd1);
        clr();
        check("t2_drop_clr", 32'(rd_drop), 32'd0);

        // Pending read address replaced while a write is in service
        ack_dly = 4;
        exp_q.push_back(mk(1'b1, 25'h200, 8'h77));
        exp_q.push_back(mk(1'b0, 25'h60, 8'h00));
        exp_rd.push_back(img(25'h60));
        wr_strobe(25'h200, 8'h77);
        wait_grant("t3");
        rd_strobe(25'h50);
        rd_strobe(25'h60);
        wait_idle("t3");
        check("t3_rd_data", 32'(rd_data), 32'h3A);
        check("t3_no_drop", 32'(rd_drop), 32'd0);

        // Anti-starvation: four writes, one read, then writes resume
        ack_dly = 2;
        g0 = n_grant;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(1'b1, 25'(32'h400 + i), 8'(8'h10 + i)));
        exp_q.push_back(mk(1'b0, 25'h80, 8'h00));
        exp_q.push_back(mk(1'b1, 25'h404, 8'h14));
        exp_rd.push_back(img(25'h80));
        wr_stb = 1'b1; wr_addr = 25'h400; wr_data = 8'h10;
        rd_stb = 1'b1; rd_addr = 25'h80;
        @(negedge clk_sys);
        wr_stb = 1'b0; rd_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_grant("t4");
            @(negedge clk_sys);
            wr_strobe(25'(32'h401 + i), 8'(8'h11 + i));
        end
        wait_idle("t4");
        check("t4_grants", 32'(n_grant - g0), 32'd6);
        check("t4_rd_data", 32'(rd_data), 32'hDA);
        check("t4_no_ovf", 32'(wr_ovf), 32'd0);

        // Overflow, set-beats-clear, then write timeout
        ack_dly = 0;
        exp_q.push_back(mk(1'b1, 25'h500, 8'h55));
        wr_strobe(25'h500, 8'h55);
        @(negedge clk_sys);
        wr_strobe(25'h501, 8'h66);
        check("t5_ovf_set", 32'(wr_ovf), 32'd1);
        clr_flags = 1'b1;
        wr_strobe(25'h502, 8'h67);
        clr_flags = 1'b0;
        check("t5_set_wins", 32'(wr_ovf), 32'd1);
        clr();
        check("t5_ovf_clr", 32'(wr_ovf), 32'd0);
        wait_idle("t5");
        check("t5_ack_err", 32'(ack_err), 32'd1);
        clr();
        check("t5_err_clr", 32'(ack_err), 32'd0);

        // Read timeout, then a normal read
        exp_q.push_back(mk(1'b0, 25'h20, 8'h00));
        exp_rd.push_back(8'hFF);
        rd_strobe(25'h20);
        wait_grant("t6");
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_sys);
            if (!mem.mem_req) break;
            n++;
        end
        check("t6_req_cycles", 32'(n), 32'd15);
        check("t6_ack_err", 32'(ack_err), 32'd1);
        check("t6_rd_valid", 32'(rd_valid), 32'd1);
        check("t6_rd_data", 32'(rd_data), 32'hFF);
        clr();
        ack_dly = 2;
        exp_q.push_back(mk(1'b0, 25'h10, 8'h00));
        exp_rd.push_back(img(25'h10));
        rd_strobe(25'h10);
        wait_idle("t6b");
        check("t6b_rd_data", 32'(rd_data), 32'h3C);
        check("t6b_no_err", 32'(ack_err), 32'd0);

        // Asynchronous reset in the middle of a write
        ack_dly = 0;
        exp_q.push_back(mk(1'b1, 25'h600, 8'h99));
        wr_strobe(25'h600, 8'h99);
        wait_grant("t7");
        wr_strobe(25'h601, 8'h01);
        check("t7_ovf_pre", 32'(wr_ovf), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t7_req", 32'(mem.mem_req), 32'd0);
        check("t7_busy", 32'(wr_busy), 32'd0);
        check("t7_ovf", 32'(wr_ovf), 32'd0);
        check("t7_drop", 32'(rd_drop), 32'd0);
        check("t7_err", 32'(ack_err), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        g0 = n_grant;
        repeat (10) @(negedge clk_sys);
        check("t7_no_grant", 32'(n_grant - g0), 32'd0);
        check("t7_req_idle", 32'(mem.mem_req), 32'd0);
        check("t7_busy_idle", 32'(wr_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 8-bit SDRAM controller port between two requesters: ROM/tape download writes from data_io, and cassette player byte reads.
- Replaces the combinational `ioctl_wr ? ioctl_addr : cas_addr` mux with a sequenced controller that has a request/acknowledge handshake, write buffering, write priority with read anti-starvation, and an acknowledge timeout.
- Sits in clk_sys between data_io/cassette and sdram.
- The cassette read strobe must already be synchronised to clk_sys before it reaches this block.

Parameters:
- ADDR_W, 25, address width of both ports and of the memory port.
- DATA_W, 8, data width.
- WR_BURST_MAX, 4, maximum consecutive write grants while a read is pending.
- ACK_TIMEOUT, 15, cycles in service without mem_ack before abort (4-bit counter, range 1..15).

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_stb  in  1  one-cycle download write strobe.
- wr_addr  in  ADDR_W  write address, sampled with wr_stb.
- wr_data  in  DATA_W  write data, sampled with wr_stb.
- wr_busy  out  1  write holding register occupied.
- rd_stb  in  1  one-cycle cassette read strobe.
- rd_addr  in  ADDR_W  read address, sampled with rd_stb.
- rd_data  out  DATA_W  last read result.
- rd_valid  out  1  one-cycle pulse when rd_data has been updated.
- mem_req  out  1  request to SDRAM controller.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  write data to memory.
- mem_dout  in  DATA_W  read data from memory, valid on the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- clr_flags  in  1  clears the sticky flags.
- wr_ovf  out  1  sticky: a write strobe was lost.
- rd_drop  out  1  sticky: a read strobe was ignored.
- ack_err  out  1  sticky: a timeout occurred.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0, except rd_data = 0.
  - State IDLE; holding registers empty; counters 0.
- All outputs are registered.
- Write holding register (1 entry):
  - wr_stb while empty: latch wr_addr/wr_data; wr_busy=1 next cycle.
  - wr_stb while full and not released this cycle: strobe discarded, wr_ovf<=1.
  - wr_stb on the same cycle the entry is released (ack or timeout): new entry accepted, no overflow.
- Read pending register (1 entry):
  - rd_stb while no read is pending: latch rd_addr.
  - rd_stb while a read is pending but not yet granted: address replaced (latest wins), no flag.
  - rd_stb while a read is in service: ignored, rd_drop<=1.
- States:
  - IDLE: write pending and (no read pending or wr_run<WR_BURST_MAX) -> WR. Read pending otherwise -> RD. Else stay in IDLE.
  - WR / RD: on entry mem_req=1, mem_we=1/0, mem_addr/mem_din taken from the holding register. These stay stable until exit.
- Exit from WR/RD on mem_ack, sampled in state:
  - Next cycle: mem_req=0, state IDLE.
  - WR: holding register freed.
  - RD: rd_data<=mem_dout, rd_valid pulses the cycle after mem_ack.
- Every grant passes through at least one IDLE cycle, so mem_req is low for at least 1 cycle between requests.
- Latency: strobe at edge N (IDLE, no contention) -> mem_req high from N+2.
- Anti-starvation counter wr_run:
  - Increments on each WR grant while a read is pending.
  - Resets to 0 on an RD grant, or when no read is pending.
- Timeout:
  - tcnt counts cycles in WR/RD and reaches ACK_TIMEOUT without mem_ack -> drop mem_req, go to IDLE, ack_err<=1.
  - WR: entry freed (data lost).
  - RD: rd_data<=all ones, rd_valid pulses.
- mem_ack while in IDLE: ignored.
- clr_flags: clears wr_ovf, rd_drop and ack_err next cycle. A flag-setting event on the same cycle wins.
- reset_n asserted mid-transaction: mem_req drops immediately; pending entries are lost.

Test Plan:
- Single write: wr_stb addr=0x000123 data=0xA5; mem_ack 3 cycles after mem_req -> mem_req high 2 cycles after strobe with mem_we=1, mem_addr=0x123, mem_din=0xA5; wr_busy low after ack.
- Single read: rd_stb addr=0x10; mem_dout=0x3C with ack -> rd_data=0x3C, rd_valid one pulse, mem_we=0.
- Starvation: read pending, continuous writes every grant, WR_BURST_MAX=4 -> exactly 4 WR grants, then one RD, then writes resume.
- Overflow: two wr_stb 1 cycle apart, no ack -> wr_ovf=1, only the first write is issued; clr_flags -> wr_ovf=0.
- Timeout: read issued, mem_ack never asserted -> mem_req drops after 15 cycles, ack_err=1, rd_data=0xFF, rd_valid pulses; next request is served normally.
- Async reset during WR (reset_n low between edges) -> mem_req, wr_busy and all flags 0 immediately; after release with no strobes, no request is issued.
